// File: rtl/i2c_des_host_master_if.sv
// rtl/i2c_des_host_master_if.sv - request, status and I2C line bundle for i2c_des_host_master
// Signals:
//   start, rw, tx_data      transaction request (host -> master)
//   sda_in                  sampled SDA line (bus -> master)
//   scl_out, sda_out        SCL drive and open-drain SDA drive, 1 = released
//   rx_data, busy, done,    read block, activity flag, end pulse,
//   ack_error               sticky NACK flag (master -> host)
interface i2c_des_host_master_if;
    logic        start;
    logic        rw;
    logic [63:0] tx_data;
    logic        sda_in;
    logic        scl_out;
    logic        sda_out;
    logic [63:0] rx_data;
    logic        busy;
    logic        done;
    logic        ack_error;

    modport master (
        input  start, rw, tx_data, sda_in,
        output scl_out, sda_out, rx_data, busy, done, ack_error
    );

    modport slave (
        output start, rw, tx_data, sda_in,
        input  scl_out, sda_out, rx_data, busy, done, ack_error
    );
endinterface

// File: rtl/i2c_des_host_master.sv
// rtl/i2c_des_host_master.sv - I2C master moving one 64-bit DES block to/from a fixed-address peripheral
// Ports:
//   clk    system clock, rising edge
//   n_rst  asynchronous active-low reset
//   bus    i2c_des_host_master_if.master (start/rw/tx_data in, sda_in in,
//          scl_out/sda_out out, rx_data/busy/done/ack_error out)
module i2c_des_host_master #(
    parameter int unsigned CLK_DIV    = 4,
    parameter logic [6:0]  SLAVE_ADDR = 7'h42
) (
    input  logic                         clk,
    input  logic                         n_rst,
    i2c_des_host_master_if.master        bus
);

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_START,
        S_ADDR,
        S_ADDR_ACK,
        S_WR_BYTE,
        S_WR_ACK,
        S_RD_BYTE,
        S_RD_ACK,
        S_STOP,
        S_DONE
    } state_t;

    state_t      state;
    state_t      state_next;

    logic [7:0]  div_cnt;
    logic [1:0]  quarter;
    logic [2:0]  bit_cnt;
    logic [2:0]  byte_cnt;
    logic        rw_q;
    logic [63:0] tx_q;
    logic [63:0] rx_shift;
    logic [63:0] rx_q;
    logic        sda_sample;
    logic        ack_err_q;

    logic        in_bit;
    logic        q_last;
    logic        sample_tick;
    logic        bit_end;
    logic        scl_mid;
    logic [7:0]  addr_byte;
    logic        addr_bit;
    logic [5:0]  tx_idx;
    logic        tx_bit;

    logic        scl_c;
    logic        sda_c;
    logic        busy_c;
    logic        done_c;

    assign in_bit      = (state != S_IDLE) && (state != S_DONE);
    assign q_last      = (div_cnt == DIV_LAST);
    assign sample_tick = q_last && (quarter == 2'd1);
    assign bit_end     = q_last && (quarter == 2'd3);
    assign scl_mid     = (quarter == 2'd1) || (quarter == 2'd2);
    assign addr_byte   = {SLAVE_ADDR, rw_q};
    assign addr_bit    = addr_byte[3'd7 - bit_cnt];
    // Byte and bit counters together form the MSB-first bit index into the block.
    assign tx_idx      = {byte_cnt, bit_cnt};
    assign tx_bit      = tx_q[6'd63 - tx_idx];

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        scl_c      = 1'b1;
        sda_c      = 1'b1;
        busy_c     = in_bit;
        done_c     = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.start) begin
                    state_next = S_START;
                end
            end
            S_START: begin
                // SCL stays high from idle so SDA can fall at Q1->Q2 as a start condition.
                scl_c = (quarter != 2'd3);
                sda_c = (quarter < 2'd2);
                if (bit_end) begin
                    state_next = S_ADDR;
                end
            end
            S_ADDR: begin
                scl_c = scl_mid;
                sda_c = addr_bit;
                if (bit_end && bit_cnt == 3'd7) begin
                    state_next = S_ADDR_ACK;
                end
            end
            S_ADDR_ACK: begin
                scl_c = scl_mid;
                if (bit_end) begin
                    if (sda_sample) begin
                        state_next = S_STOP;
                    end else if (rw_q) begin
                        state_next = S_RD_BYTE;
                    end else begin
                        state_next = S_WR_BYTE;
                    end
                end
            end
            S_WR_BYTE: begin
                scl_c = scl_mid;
                sda_c = tx_bit;
                if (bit_end && bit_cnt == 3'd7) begin
                    state_next = S_WR_ACK;
                end
            end
            S_WR_ACK: begin
                scl_c = scl_mid;
                if (bit_end) begin
                    if (sda_sample || byte_cnt == 3'd7) begin
                        state_next = S_STOP;
                    end else begin
                        state_next = S_WR_BYTE;
                    end
                end
            end
            S_RD_BYTE: begin
                scl_c = scl_mid;
                if (bit_end && bit_cnt == 3'd7) begin
                    state_next = S_RD_ACK;
                end
            end
            S_RD_ACK: begin
                scl_c = scl_mid;
                // ACK every byte but the last; NACK tells the slave to stop sending.
                sda_c = (byte_cnt == 3'd7);
                if (bit_end) begin
                    if (byte_cnt == 3'd7) begin
                        state_next = S_STOP;
                    end else begin
                        state_next = S_RD_BYTE;
                    end
                end
            end
            S_STOP: begin
                // SCL stays high after Q1 so the SDA rise in Q2 is a stop and the bus ends idle.
                scl_c = (quarter != 2'd0);
                sda_c = quarter[1];
                if (bit_end) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                done_c     = 1'b1;
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            div_cnt    <= '0;
            quarter    <= '0;
            bit_cnt    <= '0;
            byte_cnt   <= '0;
            rw_q       <= 1'b0;
            tx_q       <= '0;
            rx_shift   <= '0;
            rx_q       <= '0;
            sda_sample <= 1'b1;
            ack_err_q  <= 1'b0;
        end else begin
            if (state == S_IDLE && bus.start) begin
                rw_q      <= bus.rw;
                tx_q      <= bus.tx_data;
                ack_err_q <= 1'b0;
                div_cnt   <= '0;
                quarter   <= '0;
                bit_cnt   <= '0;
                byte_cnt  <= '0;
            end
            if (in_bit) begin
                if (q_last) begin
                    div_cnt <= '0;
                    quarter <= quarter + 2'd1;
                end else begin
                    div_cnt <= div_cnt + 8'd1;
                end
                if (sample_tick) begin
                    sda_sample <= bus.sda_in;
                    if (state == S_RD_BYTE) begin
                        rx_shift <= {rx_shift[62:0], bus.sda_in};
                    end
                end
                if (bit_end) begin
                    if (state == S_ADDR || state == S_WR_BYTE || state == S_RD_BYTE) begin
                        bit_cnt <= bit_cnt + 3'd1;
                    end
                    // Wraps 7->0 on the final ACK slot, which is always the end of the transfer.
                    if (state == S_WR_ACK || state == S_RD_ACK) begin
                        byte_cnt <= byte_cnt + 3'd1;
                    end
                    if ((state == S_ADDR_ACK || state == S_WR_ACK) && sda_sample) begin
                        ack_err_q <= 1'b1;
                    end
                end
            end
            if (state == S_DONE && rw_q && !ack_err_q) begin
                rx_q <= rx_shift;
            end
        end
    end

    assign bus.scl_out   = scl_c;
    assign bus.sda_out   = sda_c;
    assign bus.busy      = busy_c;
    assign bus.done      = done_c;
    assign bus.ack_error = ack_err_q;
    // The new block is already visible during the done cycle, then held in rx_q.
    assign bus.rx_data   = (state == S_DONE && rw_q && !ack_err_q) ? rx_shift : rx_q;

endmodule

// File: tb/tb_i2c_des_host_master.sv
// tb/tb_i2c_des_host_master.sv - randomized bench with I2C slave model for i2c_des_host_master
module tb_i2c_des_host_master;

    localparam int         CLK_DIV    = 4;
    localparam logic [6:0] SLAVE_ADDR = 7'h42;

    logic clk   = 1'b0;
    logic n_rst = 1'b0;

    i2c_des_host_master_if bus();

    i2c_des_host_master #(
        .CLK_DIV   (CLK_DIV),
        .SLAVE_ADDR(SLAVE_ADDR)
    ) dut (
        .clk  (clk),
        .n_rst(n_rst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        slave_drive = 1'b1;
    assign bus.sda_in = bus.sda_out & slave_drive;

    logic        prev_scl = 1'b1;
    logic        prev_sda = 1'b1;
    logic        scl_v;
    logic        sda_v;
    bit          in_txn = 1'b0;
    bit          rd = 1'b0;
    int          sclk = 0;
    int          bitno;
    int          byteno;
    logic [7:0]  shift = 8'h00;
    logic [7:0]  got_bytes[$];
    logic        m_acks[$];
    int          start_cnt = 0;
    int          stop_cnt = 0;
    int          t_edge = 0;
    bit          low_ok = 1'b0;
    bit          high_ok = 1'b0;
    bit          cfg_nack_addr = 1'b0;
    int          cfg_nack_byte = -1;
    logic [7:0]  rd_bytes[8];
    logic [63:0] exp_rx = 64'h0;

    // Slave: decodes START/STOP and clocked bits from the lines, answers ACKs and read data.
    always @(negedge clk) begin
        if (!n_rst) begin
            in_txn      = 1'b0;
            slave_drive = 1'b1;
            low_ok      = 1'b0;
            high_ok     = 1'b0;
            prev_scl    = 1'b1;
            prev_sda    = 1'b1;
        end else begin
            scl_v = bus.scl_out;
            sda_v = bus.sda_in;
            if (scl_v && prev_scl && sda_v != prev_sda) begin
                if (!sda_v) begin
                    start_cnt++;
                    in_txn      = 1'b1;
                    sclk        = 0;
                    rd          = 1'b0;
                    shift       = 8'h00;
                    slave_drive = 1'b1;
                end else begin
                    stop_cnt++;
                    in_txn      = 1'b0;
                    slave_drive = 1'b1;
                end
            end
            if (scl_v && !prev_scl) begin
                if (low_ok) check_val("scl_low_len", 64'(cyc - t_edge), 64'(2 * CLK_DIV));
                t_edge  = cyc;
                high_ok = 1'b1;
                if (in_txn) begin
                    bitno  = sclk % 9;
                    byteno = sclk / 9;
                    if (bitno < 8) shift = {shift[6:0], sda_v};
                    if (bitno == 7 && (byteno == 0 || !rd)) begin
                        got_bytes.push_back(shift);
                        if (byteno == 0) rd = shift[0];
                    end
                    if (bitno == 8 && byteno >= 1 && rd) m_acks.push_back(sda_v);
                    sclk++;
                end
            end
            if (!scl_v && prev_scl) begin
                if (high_ok) check_val("scl_high_len", 64'(cyc - t_edge), 64'(2 * CLK_DIV));
                t_edge = cyc;
                low_ok = 1'b1;
                if (in_txn) begin
                    bitno  = sclk % 9;
                    byteno = sclk / 9;
                    if (byteno == 0) slave_drive = (bitno == 8) ? cfg_nack_addr : 1'b1;
                    else if (cfg_nack_addr || byteno > 8) slave_drive = 1'b1;
                    else if (!rd) slave_drive = (bitno == 8 && (byteno - 1) != cfg_nack_byte) ? 1'b0 : 1'b1;
                    else slave_drive = (bitno < 8) ? rd_bytes[byteno - 1][7 - bitno] : 1'b1;
                end
            end
            prev_scl = scl_v;
            prev_sda = sda_v;
        end
    end

    task automatic run_txn(input bit r, input logic [63:0] d, input bit na, input int nb,
                           input bit poke, input string tag);
        int         nbytes;
        int         exp_lat;
        int         acc;
        int         lat;
        bit         got_done;
        bit         exp_err;
        logic [7:0] exp_bytes[$];
        logic [7:0] ackv;

        cfg_nack_addr = na;
        cfg_nack_byte = nb;
        start_cnt = 0;
        stop_cnt  = 0;
        got_bytes.delete();
        m_acks.delete();

        exp_bytes.push_back({SLAVE_ADDR, r});
        nbytes = na ? 0 : (r ? 8 : ((nb >= 0) ? nb + 1 : 8));
        if (!r) for (int i = 0; i < nbytes; i++) exp_bytes.push_back(d[63 - 8 * i -: 8]);
        exp_err = na || (!r && nb >= 0);
        if (r && !na) for (int i = 0; i < 8; i++) exp_rx[63 - 8 * i -: 8] = rd_bytes[i];
        exp_lat = (11 + 9 * nbytes) * 4 * CLK_DIV;

        @(negedge clk);
        bus.start   = 1'b1;
        bus.rw      = r;
        bus.tx_data = d;
        @(negedge clk);
        bus.start   = 1'b0;
        bus.rw      = ~r;
        bus.tx_data = ~d;
        high_ok     = 1'b0;
        acc         = cyc;
        check_val({tag, " busy_on_accept"}, 64'(bus.busy), 64'd1);
        check_val({tag, " ack_err_cleared"}, 64'(bus.ack_error), 64'd0);

        got_done = 1'b0;
        for (int k = 0; k < 3000 && !got_done; k++) begin
            if (poke && k == 200) begin
                bus.start   = 1'b1;
                bus.rw      = ~r;
                bus.tx_data = ~d;
            end
            if (poke && k == 201) bus.start = 1'b0;
            @(negedge clk);
            if (bus.done) got_done = 1'b1;
        end
        check_val({tag, " done_seen"}, 64'(got_done), 64'd1);
        if (got_done) begin
            lat = cyc - acc;
            check_val({tag, " latency"},
                      64'((lat >= exp_lat - 2 && lat <= exp_lat + 2) ? exp_lat : lat), 64'(exp_lat));
            check_val({tag, " busy_at_done"}, 64'(bus.busy), 64'd0);
            check_val({tag, " ack_error"}, 64'(bus.ack_error), 64'(exp_err));
            check_val({tag, " rx_at_done"}, bus.rx_data, exp_rx);
            @(negedge clk);
            check_val({tag, " done_width"}, 64'(bus.done), 64'd0);
            check_val({tag, " rx_hold"}, bus.rx_data, exp_rx);
        end

        check_val({tag, " n_bytes"}, 64'(got_bytes.size()), 64'(exp_bytes.size()));
        for (int i = 0; i < exp_bytes.size() && i < got_bytes.size(); i++)
            check_val($sformatf("%s byte%0d", tag, i), 64'(got_bytes[i]), 64'(exp_bytes[i]));
        check_val({tag, " starts"}, 64'(start_cnt), 64'd1);
        check_val({tag, " stops"}, 64'(stop_cnt), 64'd1);
        if (r && !na) begin
            ackv = 8'h00;
            foreach (m_acks[i]) ackv = {ackv[6:0], m_acks[i]};
            check_val({tag, " n_master_acks"}, 64'(m_acks.size()), 64'd8);
            check_val({tag, " master_acks"}, 64'(ackv), 64'h01);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [63:0] d;
        bit          r;
        bit          na;
        int          nb;

        bus.start   = 1'b0;
        bus.rw      = 1'b0;
        bus.tx_data = 64'h0;
        n_rst       = 1'b0;
        repeat (3) @(negedge clk);
        check_val("rst scl_out", 64'(bus.scl_out), 64'd1);
        check_val("rst sda_out", 64'(bus.sda_out), 64'd1);
        check_val("rst busy", 64'(bus.busy), 64'd0);
        check_val("rst done", 64'(bus.done), 64'd0);
        check_val("rst ack_error", 64'(bus.ack_error), 64'd0);
        check_val("rst rx_data", bus.rx_data, 64'h0);
        n_rst = 1'b1;
        @(negedge clk);

        run_txn(1'b0, 64'h0123456789ABCDEF, 1'b0, -1, 1'b0, "wr_basic");

        rd_bytes = '{8'hFE, 8'hDC, 8'hBA, 8'h98, 8'h76, 8'h54, 8'h32, 8'h10};
        run_txn(1'b1, 64'h0, 1'b0, -1, 1'b0, "rd_basic");

        for (int i = 0; i < 8; i++) rd_bytes[i] = 8'($urandom);
        run_txn(1'b1, {$urandom, $urandom}, 1'b1, -1, 1'b0, "addr_nack");

        run_txn(1'b0, {$urandom, $urandom}, 1'b0, 3, 1'b0, "wr_nack3");
        run_txn(1'b0, {$urandom, $urandom}, 1'b0, -1, 1'b0, "wr_after_nack");

        run_txn(1'b0, {$urandom, $urandom}, 1'b0, -1, 1'b1, "wr_poke");

        for (int i = 0; i < 8; i++) rd_bytes[i] = 8'($urandom);
        cfg_nack_addr = 1'b0;
        cfg_nack_byte = -1;
        start_cnt = 0;
        stop_cnt  = 0;
        @(negedge clk);
        bus.start   = 1'b1;
        bus.rw      = 1'b1;
        bus.tx_data = {$urandom, $urandom};
        @(negedge clk);
        bus.start = 1'b0;
        high_ok   = 1'b0;
        repeat (22 * 4 * CLK_DIV + CLK_DIV / 2 - 1) @(negedge clk);
        check_val("abort busy_before", 64'(bus.busy), 64'd1);
        n_rst = 1'b0;
        #1;
        check_val("abort scl_out", 64'(bus.scl_out), 64'd1);
        check_val("abort sda_out", 64'(bus.sda_out), 64'd1);
        check_val("abort busy", 64'(bus.busy), 64'd0);
        check_val("abort done", 64'(bus.done), 64'd0);
        check_val("abort rx_data", bus.rx_data, 64'h0);
        exp_rx = 64'h0;
        repeat (3) @(negedge clk);
        n_rst = 1'b1;
        @(negedge clk);
        check_val("abort no_stop", 64'(stop_cnt), 64'd0);
        check_val("abort idle_scl", 64'(bus.scl_out), 64'd1);

        for (int i = 0; i < 8; i++) rd_bytes[i] = 8'($urandom);
        run_txn(1'b1, {$urandom, $urandom}, 1'b0, -1, 1'b0, "rd_after_rst");

        for (int t = 0; t < 8; t++) begin
            r  = 1'($urandom_range(0, 1));
            d  = {$urandom, $urandom};
            na = ($urandom_range(0, 5) == 0);
            nb = (!r && $urandom_range(0, 2) == 0) ? int'($urandom_range(0, 7)) : -1;
            for (int i = 0; i < 8; i++) rd_bytes[i] = 8'($urandom);
            run_txn(r, d, na, nb, 1'b0, $sformatf("rand%0d", t));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/i2c_des_host_master.md
I2C_DES_HOST_MASTER -- requirements
Module: i2c_des_host_master

Interface
REQ-001 Parameter CLK_DIV, default 4, system clocks per SCL quarter-phase (legal range 2..255).
REQ-002 Parameter SLAVE_ADDR, default 7'h42, 7-bit I2C address of the DES peripheral.
REQ-003 clk  input  1  system clock; all state changes on its rising edge.
REQ-004 n_rst  input  1  asynchronous active-low reset.
REQ-005 start  input  1  request pulse; sampled high while idle starts a transaction.
REQ-006 rw  input  1  0 = write block to peripheral, 1 = read block from peripheral.
REQ-007 tx_data  input  64  block to write; byte 0 = tx_data[63:56].
REQ-008 sda_in  input  1  sampled SDA line.
REQ-009 scl_out  output  1  SCL drive; 1 = released/high.
REQ-010 sda_out  output  1  SDA open-drain drive; 0 = pull low, 1 = release.
REQ-011 rx_data  output  64  last successfully read block; first received byte in [63:56].
REQ-012 busy  output  1  high from accepted start until done.
REQ-013 done  output  1  one-cycle pulse at transaction end.
REQ-014 ack_error  output  1  sticky; set on any NACK from slave.

Function
REQ-015 The module SHALL accept start only when busy=0; start while busy SHALL be ignored.
REQ-016 On acceptance it SHALL latch rw and tx_data, clear ack_error, and assert busy on the next cycle.
REQ-017 Each bit-time SHALL be 4 quarter-phases of CLK_DIV clocks: Q0 SCL low and SDA updated, Q1/Q2 SCL high, Q3 SCL low.
REQ-018 sda_in SHALL be sampled on the last clock of Q1.
REQ-019 States: IDLE, START, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, STOP, DONE.
REQ-020 START: SDA falls while SCL high (Q1->Q2), one bit-time.
REQ-021 ADDR: sends {SLAVE_ADDR, rw} MSB first, 8 bit-times.
REQ-022 ADDR_ACK: SDA released for 1 bit-time; sampled 0 -> WR_BYTE (rw=0) or RD_BYTE (rw=1); sampled 1 -> set ack_error, go to STOP.
REQ-023 WR_BYTE/WR_ACK: sends 8 bytes MSB first. A NACK on any byte SHALL set ack_error and go to STOP without sending further bytes.
REQ-024 RD_BYTE/RD_ACK: shifts 8 bytes MSB first. The master SHALL drive ACK (SDA=0) after bytes 0-6 and NACK (SDA released) after byte 7.
REQ-025 A 3-bit byte counter SHALL wrap 7->0 only at transaction end, with no extra bytes sent.
REQ-026 STOP: SDA low in Q0, SCL rises Q1, SDA released in Q2; one bit-time.
REQ-027 DONE: done=1 for exactly one cycle, busy=0 in that same cycle, then IDLE.
REQ-028 rx_data SHALL update only in DONE of a read with ack_error=0; otherwise it holds.
REQ-029 Latency, error-free: start accept to done = 83 bit-times x 4 x CLK_DIV clocks +/- 2 cycles (1 START + 9 address + 72 data/ack + 1 STOP).
REQ-030 SDA SHALL never change while SCL is high, except in START and STOP.
REQ-031 In IDLE, scl_out=1 and sda_out=1.

Reset
REQ-032 While n_rst=0, outputs SHALL be immediately: scl_out=1, sda_out=1, busy=0, done=0, ack_error=0, rx_data=0; state IDLE; counters 0.
REQ-033 Reset mid-transaction SHALL release the bus immediately, with no STOP generated. The first start after reset release SHALL be accepted normally.

Verification
REQ-034 Write, CLK_DIV=4, tx_data=64'h0123456789ABCDEF, slave ACKs all -> bus bytes 0x84,01,23,45,67,89,AB,CD,EF; done after 1328+/-2 clocks; ack_error=0.
REQ-035 Read, slave returns FE DC BA 98 76 54 32 10 -> address byte 0x85; master ACKs 7 bytes, NACKs last; rx_data=64'hFEDCBA9876543210 at done.
REQ-036 Address NACK (sda_in held 1) -> ack_error=1; STOP follows immediately after ADDR_ACK; done pulses; rx_data unchanged.
REQ-037 Write with NACK on byte 3 -> bytes 4-7 not sent; STOP; ack_error=1. A following good write clears ack_error.
REQ-038 start pulsed during busy, and n_rst asserted mid-RD_BYTE -> second start ignored; on reset scl_out=sda_out=1 and busy=0 within the reset assertion; next start completes normally.
REQ-039 A protocol checker on all tests -> zero SDA transitions while SCL is high outside START/STOP; SCL high/low each 2 x CLK_DIV clocks.
